keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad.
- Drives one column low at a time and samples the active-low rows.
- Debounces over whole scans and emits a one-clock key event with a 4-bit key index.
- Input-side counterpart of seven_seg_scanner: that block drives anodes out, this one scans keys in. It feeds operand entry in top in place of raw sw bits.

Parameters:
- SCAN_DIV, 1000: clocks each column is driven (dwell). Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan snapshots required before the debounced state updates. Must be >= 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- row  in  4  keypad rows, active-low (external pull-ups); asynchronous to clock.
- col  out  4  keypad columns, one-cold; col[c]=0 drives column c.
- key_code  out  4  index of the last accepted key = col*4 + row.
- key_valid  out  1  one-clock pulse when a new single key is accepted.
- key_held  out  1  high while the accepted key remains the only debounced key.

Behaviour:
- Reset (reset=0, asynchronous), all registers cleared:
  - col=4'b1110, dwell counter=0, column index=0.
  - Row synchronizer=4'b1111; snapshot and debounced map all-released.
  - Stable counter=0, state IDLE.
  - key_code=0, key_valid=0, key_held=0.
- Row input passes through a 2-flop synchronizer before any use.
- Column scan:
  - Dwell counter runs 0..SCAN_DIV-1 per column.
  - In the last dwell cycle (count=SCAN_DIV-1), synchronized row bits are captured into snapshot bits [c*4+3:c*4], inverted so 1=pressed.
  - Next clock: column index advances 0->1->2->3->0 and col rotates accordingly.
  - One full scan = 4*SCAN_DIV clocks.
- End of scan (capture of column 3):
  - Compare the completed 16-bit snapshot to the previous completed snapshot.
  - Equal: stable counter increments, saturating at DEBOUNCE_SCANS.
  - Different: stable counter reset to 1.
  - When the counter reaches DEBOUNCE_SCANS, the debounced map loads the snapshot. The map is only ever updated at scan end.
- FSM, evaluated the clock after each debounced-map update:
  - IDLE:
    - Map has exactly one bit set -> latch key_code=index of that bit, pulse key_valid, go to PRESSED.
    - Map has >=2 bits set -> LOCKED.
    - Map empty -> stay.
  - PRESSED:
    - Map empty -> IDLE.
    - Map equals the single latched key -> stay.
    - Any other non-empty map -> LOCKED.
  - LOCKED: map empty -> IDLE; otherwise stay.
- key_held=1 only in PRESSED. key_valid is registered and high for exactly one clock per IDLE->PRESSED transition.
- key_code holds its value through IDLE and LOCKED; it changes only with key_valid.
- No auto-repeat: holding a key never re-pulses.
- Rollover (press B while A held): no event; the keypad must fully release before the next event.
- Multiple simultaneous keys never produce an event (ghosting-safe).
- Reset mid-scan or mid-press: immediate return to reset values. A key still held after reset release is accepted as a new press once debounced.
- Latency: press stable before a scan start -> key_valid within DEBOUNCE_SCANS+1 scans plus 3 clocks.

Test Plan:
All tests use SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan=16 clocks). The bench models the matrix: row[r]=0 iff col[c]=0 and key(c,r) is pressed.
- Reset: hold reset=0 with random row -> col=1110, key_code=0, key_valid=0, key_held=0. After release, col steps 1110,1101,1011,0111,1110 every 4 clocks.
- Single press key(c=2,r=1), held 10 scans -> exactly one key_valid pulse, key_code=9, key_held=1 from the pulse clock. Pulse lands within 4 scans+3 clocks of press. No further pulses.
- Bounce: key(0,3) toggled for 1 scan, released 1 scan, repeated 3 times, then released -> no key_valid, key_code unchanged.
- Two keys (1,0) and (3,2) pressed together -> no pulse, key_held=0. Release all, then press (3,3) -> one pulse, key_code=15.
- Rollover: hold (0,0) until accepted (code 0), add (0,1), then release (0,0) only -> no new pulse until all released. Then press (0,1) again -> pulse, code 1.
- Reset mid-press: hold (2,2) until key_held=1, pulse reset=0 for 3 clocks -> outputs cleared immediately. With the key still held, one new pulse with code 10 arrives after debounce.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key event seen by the consumer.
// The master side is the scanner; the slave side is the keypad/consumer.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, whole-scan debounce,
// and a single-key event FSM that ignores rollover and multi-key chords.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clock,
    input  logic             reset,
    keypad_scanner_if.master kp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic is_single(input logic [15:0] m);
        return (m != 16'd0) && ((m & (m - 16'd1)) == 16'd0);
    endfunction

    function automatic logic [3:0] key_index(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    logic [3:0]    row_meta_q, row_meta_d;
    logic [3:0]    row_sync_q, row_sync_d;
    logic [DW-1:0] dwell_q,    dwell_d;
    logic [1:0]    col_idx_q,  col_idx_d;
    logic [3:0]    col_q,      col_d;
    logic [15:0]   snap_q,     snap_d;
    logic [15:0]   prev_q,     prev_d;
    logic [SW-1:0] stable_q,   stable_d;
    logic [15:0]   map_q,      map_d;
    logic          map_upd_q,  map_upd_d;
    state_t        state_q,    state_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;

    logic dwell_last;
    logic scan_end;

    // Scan timing, snapshot capture and whole-scan debounce
    always_comb begin
        row_meta_d = kp.row;
        row_sync_d = row_meta_q;

        dwell_last = (dwell_q == DWELL_LAST);
        scan_end   = dwell_last && (col_idx_q == 2'd3);

        dwell_d   = dwell_last ? '0 : dwell_q + DW'(1);
        col_idx_d = dwell_last ? col_idx_q + 2'd1 : col_idx_q;
        col_d     = ~(4'b0001 << col_idx_d);

        snap_d    = snap_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        map_d     = map_q;
        map_upd_d = 1'b0;

        if (dwell_last) begin
            // Rows are active-low; store 1 = pressed.
            snap_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
        end

        if (scan_end) begin
            if (snap_d == prev_q) begin
                stable_d = (stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
            end else begin
                stable_d = SW'(1);
            end
            prev_d = snap_d;
            if (stable_d == STABLE_MAX) begin
                map_d     = snap_d;
                map_upd_d = 1'b1;
            end
        end
    end

    // Key event FSM, stepped only on the clock after a debounced-map load
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        if (map_upd_q) begin
            unique case (state_q)
                IDLE: begin
                    if (is_single(map_q)) begin
                        key_code_d  = key_index(map_q);
                        key_valid_d = 1'b1;
                        state_d     = PRESSED;
                    end else if (map_q != 16'd0) begin
                        state_d = LOCKED;
                    end
                end
                PRESSED: begin
                    if (map_q == 16'd0) begin
                        state_d = IDLE;
                    end else if (map_q != (16'd1 << key_code_q)) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (map_q == 16'd0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            snap_q      <= 16'd0;
            prev_q      <= 16'd0;
            stable_q    <= '0;
            map_q       <= 16'd0;
            map_upd_q   <= 1'b0;
            state_q     <= IDLE;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            map_q       <= map_d;
            map_upd_q   <= map_upd_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign kp.col       = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = (state_q == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational model of the key matrix.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int SCAN     = 4 * SCAN_DIV;
    localparam int LAT      = (DEB + 1) * SCAN + 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp   (kif.master)
    );

    logic [15:0] pressed = 16'd0;
    logic [3:0]  row_model;
    int checks    = 0;
    int passed    = 0;
    int pulse_cnt = 0;
    int cyc       = 0;

    // row[r] is pulled low when the driven column has key (c,r) pressed
    always_comb begin
        row_model = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kif.col[c] && pressed[c*4+r]) row_model[r] = 1'b0;
            end
        end
    end
    assign kif.row = row_model;

    always @(posedge clock) begin
        if (kif.key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic align_scan();
        while (cyc % SCAN != 0) cycles(1);
    endtask

    task automatic wait_pulse(input string tag, input logic [3:0] code, output int n);
        logic got;
        got = 1'b0;
        n   = 0;
        for (int i = 1; i <= LAT + SCAN; i++) begin
            cycles(1);
            if (kif.key_valid === 1'b1) begin
                got = 1'b1;
                n   = i;
                break;
            end
        end
        check({tag, "_pulse"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_code"}, 32'(kif.key_code), 32'(code));
            check({tag, "_held"}, 32'(kif.key_held), 32'd1);
            cycles(1);
            check({tag, "_one_clk"}, 32'(kif.key_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        logic [3:0] exp_col [4];
        exp_col[0] = 4'b1101; exp_col[1] = 4'b1011; exp_col[2] = 4'b0111; exp_col[3] = 4'b1110;

        // Reset with arbitrary rows asserted
        pressed = 16'($urandom);
        cycles(3);
        check("rst_col",   32'(kif.col),       32'hE);
        check("rst_code",  32'(kif.key_code),  32'd0);
        check("rst_valid", 32'(kif.key_valid), 32'd0);
        check("rst_held",  32'(kif.key_held),  32'd0);
        pressed = 16'd0;
        reset = 1'b1;
        check("rel_col", 32'(kif.col), 32'hE);
        for (int k = 0; k < 4; k++) begin
            cycles(SCAN_DIV);
            check($sformatf("col_step%0d", k), 32'(kif.col), 32'(exp_col[k]));
        end

        // Single press of key(2,1)
        align_scan();
        pressed = 16'd1 << 9;
        wait_pulse("single", 4'd9, n);
        check("single_lat_ok", 32'(n <= LAT), 32'd1);
        base = pulse_cnt;
        cycles(10 * SCAN);
        check("single_no_repeat", 32'(pulse_cnt - base), 32'd0);
        check("single_still_held", 32'(kif.key_held), 32'd1);
        pressed = 16'd0;
        cycles(5 * SCAN);
        check("single_release_held", 32'(kif.key_held), 32'd0);

        // Bounce on key(0,3)
        align_scan();
        base = pulse_cnt;
        for (int k = 0; k < 3; k++) begin
            pressed = 16'd1 << 3;
            cycles(SCAN);
            pressed = 16'd0;
            cycles(SCAN);
        end
        cycles(5 * SCAN);
        check("bounce_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("bounce_code", 32'(kif.key_code), 32'd9);

        // Two-key chord, then clean press of key(3,3)
        align_scan();
        base = pulse_cnt;
        pressed = (16'd1 << 4) | (16'd1 << 14);
        cycles(6 * SCAN);
        check("chord_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("chord_held", 32'(kif.key_held), 32'd0);
        pressed = 16'd0;
        cycles(5 * SCAN);
        align_scan();
        pressed = 16'd1 << 15;
        wait_pulse("after_chord", 4'd15, n);
        pressed = 16'd0;
        cycles(5 * SCAN);

        // Rollover: hold (0,0), add (0,1), drop (0,0)
        align_scan();
        pressed = 16'd1 << 0;
        wait_pulse("roll_first", 4'd0, n);
        base = pulse_cnt;
        pressed = 16'b11;
        cycles(6 * SCAN);
        check("roll_both_held", 32'(kif.key_held), 32'd0);
        pressed = 16'b10;
        cycles(6 * SCAN);
        check("roll_second_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("roll_second_held", 32'(kif.key_held), 32'd0);
        check("roll_code_kept", 32'(kif.key_code), 32'd0);
        pressed = 16'd0;
        cycles(5 * SCAN);
        check("roll_release_no_pulse", 32'(pulse_cnt - base), 32'd0);
        pressed = 16'b10;
        wait_pulse("roll_again", 4'd1, n);
        pressed = 16'd0;
        cycles(5 * SCAN);

        // Reset while key(2,2) is held
        align_scan();
        pressed = 16'd1 << 10;
        wait_pulse("pre_reset", 4'd10, n);
        reset = 1'b0;
        #1;
        check("mid_rst_col",   32'(kif.col),       32'hE);
        check("mid_rst_code",  32'(kif.key_code),  32'd0);
        check("mid_rst_held",  32'(kif.key_held),  32'd0);
        check("mid_rst_valid", 32'(kif.key_valid), 32'd0);
        cycles(3);
        reset = 1'b1;
        wait_pulse("post_reset", 4'd10, n);
        base = pulse_cnt;
        cycles(4 * SCAN);
        check("post_reset_single", 32'(pulse_cnt - base), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
